// File: rtl/vga_pkg.sv
// Shared constants, pixel types and helpers for the VGA scanout path.
package vga_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;

  localparam int unsigned VGA_H_ACTIVE = 2 * FB_WIDTH;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 2 * FB_HEIGHT;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int ADDR_W = 17;
  localparam int CNT_W  = 10;

  typedef struct packed {
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
  } rgb565_t;

  function automatic rgb565_t rgb565_split(input logic [15:0] word);
    rgb565_t px;
    px.red   = word[15:11];
    px.green = word[10:5];
    px.blue  = word[4:0];
    return px;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync, active-area and frame-boundary
// decode. All outputs are combinational views of the current counter state.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CNT_W-2:0] fb_col,
  output logic             active,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             frame_first,
  output logic             fb_line_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_cnt == H_MAX);
  assign v_last = (v_cnt == V_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CNT_ONE;
    end else begin
      h_cnt <= h_cnt + CNT_ONE;
    end
  end

  // Two output columns share one framebuffer column.
  assign fb_col      = h_cnt[CNT_W-1:1];
  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_n     = !((h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END));
  assign vsync_n     = !((v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END));
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);
  assign fb_line_end = h_last && v_cnt[0] && (v_cnt < V_ACT);
  assign frame_end   = h_last && v_last;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, 2x-replicated VRAM addressing and a 3-stage
// alignment pipeline matching the VRAM's one-cycle registered read.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_vram_address,
  input  logic [15:0]       i_vram_rd_data,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [4:0]        o_red,
  output logic [5:0]        o_green,
  output logic [4:0]        o_blue,
  output logic              o_frame_start
);

  localparam logic [ADDR_W-1:0] FB_STRIDE = ADDR_W'(H_ACTIVE / 2);

  logic [CNT_W-2:0]  fb_col;
  logic              active;
  logic              hsync_n;
  logic              vsync_n;
  logic              frame_first;
  logic              fb_line_end;
  logic              frame_end;
  logic              frame_en;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] pixel_offset;
  logic              de0;
  logic [1:0]        hs_pipe;
  logic [1:0]        vs_pipe;
  logic [1:0]        de_pipe;
  logic [1:0]        fs_pipe;
  rgb565_t           px;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .fb_col      (fb_col),
    .active      (active),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_first (frame_first),
    .fb_line_end (fb_line_end),
    .frame_end   (frame_end)
  );

  assign pixel_offset = {{(ADDR_W - (CNT_W - 1)){1'b0}}, fb_col};
  assign de0          = active && frame_en;
  assign px           = rgb565_split(i_vram_rd_data);

  // Enable is only honoured at frame boundaries so a frame is never torn.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_en <= 1'b0;
    end else if (frame_end) begin
      frame_en <= i_enable;
    end
  end

  // Row base advances one framebuffer row after every second visible line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_base <= '0;
    end else if (frame_end) begin
      line_base <= '0;
    end else if (fb_line_end) begin
      line_base <= line_base + FB_STRIDE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vram_address <= '0;
    end else if (active) begin
      o_vram_address <= line_base + pixel_offset;
    end
  end

  // Control signals ride alongside the address/data path for three clocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_pipe       <= '1;
      vs_pipe       <= '1;
      de_pipe       <= '0;
      fs_pipe       <= '0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
    end else begin
      hs_pipe       <= {hs_pipe[0], hsync_n};
      vs_pipe       <= {vs_pipe[0], vsync_n};
      de_pipe       <= {de_pipe[0], de0};
      fs_pipe       <= {fs_pipe[0], frame_first};
      o_hsync       <= hs_pipe[1];
      o_vsync       <= vs_pipe[1];
      o_de          <= de_pipe[1];
      o_frame_start <= fs_pipe[1];
      o_red         <= de_pipe[1] ? px.red   : '0;
      o_green       <= de_pipe[1] ? px.green : '0;
      o_blue        <= de_pipe[1] ? px.blue  : '0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: full 800-clock lines, shortened 12-line frame
// (8 visible lines) so each frame is 9600 clocks.
module tb_vga_scanout;

  localparam int H_ACT = 640;
  localparam int V_ACT = 8;
  localparam int FBW   = 320;
  localparam int F     = 800 * 12;
  localparam int NPIX  = H_ACT * V_ACT;

  typedef struct {
    logic [15:0] word;
    bit          first;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [16:0] vram_address;
  logic [15:0] vram_rd_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic        frame_start;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          de_seen = 0;
  int          pix_idx = 0;
  bit          colour_mode = 0;
  logic [15:0] cap [0:NPIX-1];

  vga_scanout #(
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .o_vram_address (vram_address),
    .i_vram_rd_data (vram_rd_data),
    .o_hsync        (hsync),
    .o_vsync        (vsync),
    .o_de           (de),
    .o_red          (red),
    .o_green        (green),
    .o_blue         (blue),
    .o_frame_start  (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [15:0] mem_word(input logic [16:0] a);
    if (colour_mode && a == 17'd0) return 16'hF81F;
    if (colour_mode && a == 17'd1) return 16'h07E0;
    return a[15:0];
  endfunction

  // Behavioural VRAM read port: one-clock registered latency.
  always @(posedge clk) vram_rd_data <= mem_word(vram_address);

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: actual %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        exp_t e;
        e.word  = mem_word(17'((y / 2) * FBW + x / 2));
        e.first = (x == 0 && y == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      check_output("wait_cyc_target", cyc, target);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "[TB] cycle wait did not reach its target");
    end
  endtask

  // Monitor: pops one expectation for every output clock with de high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start) pix_idx = 0;
      if (de) begin
        de_seen++;
        if (pix_idx < NPIX) cap[pix_idx] = {red, green, blue};
        pix_idx++;
        if (exp_q.size() == 0) begin
          check_output("de_without_expectation", int'(de), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("pixel_word", int'({red, green, blue}), int'(e.word));
          check_output("frame_start_on_pixel", int'(frame_start), int'(e.first));
        end
      end else begin
        check_output("rgb_zero_when_idle", int'({red, green, blue}), 0);
      end
    end
  end

  // Sync geometry: pulse widths and periods, restarted after every reset.
  int   tick, hs_fall, vs_fall, fs_last, hs_run, vs_run;
  bit   hs_ok, vs_ok, fs_ok;
  logic hs_prev, vs_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      tick = 0; hs_ok = 0; vs_ok = 0; fs_ok = 0;
      hs_run = 0; vs_run = 0; hs_prev = 1'b1; vs_prev = 1'b1;
    end else begin
      tick++;
      if (hs_prev && !hsync) begin
        if (hs_ok) check_output("hsync_period", tick - hs_fall, 800);
        hs_fall = tick; hs_ok = 1; hs_run = 1;
      end else if (!hsync) begin
        hs_run++;
      end
      if (!hs_prev && hsync && hs_ok) check_output("hsync_low_width", hs_run, 96);
      if (vs_prev && !vsync) begin
        if (vs_ok) check_output("vsync_period", tick - vs_fall, F);
        vs_fall = tick; vs_ok = 1; vs_run = 1;
      end else if (!vsync) begin
        vs_run++;
      end
      if (!vs_prev && vsync && vs_ok) check_output("vsync_low_width", vs_run, 1600);
      if (frame_start) begin
        if (fs_ok) check_output("frame_length", tick - fs_last, F);
        fs_last = tick; fs_ok = 1;
      end
      hs_prev = hsync;
      vs_prev = vsync;
    end
  end

  task automatic apply_stimulus();
    int snap;
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("reset_hsync", int'(hsync), 1);
    check_output("reset_vsync", int'(vsync), 1);
    check_output("reset_de", int'(de), 0);
    check_output("reset_address", int'(vram_address), 0);
    check_output("reset_frame_start", int'(frame_start), 0);
    rst_n = 1'b1;
    push_frame();

    wait_cyc(1);
    snap = de_seen;
    wait_cyc(F + 1);
    check_output("frame0_blank_de_count", de_seen - snap, 0);
    snap = de_seen;

    wait_cyc(F + 4 * 800 + 100);
    enable = 1'b0;
    wait_cyc(2 * F + 1);
    check_output("frame1_de_count", de_seen - snap, NPIX);
    check_output("frame1_queue_drained", exp_q.size(), 0);
    snap = de_seen;
    check_output("line0_px0", int'(cap[0]), 16'h0000);
    check_output("line0_px1", int'(cap[1]), 16'h0000);
    check_output("line0_px2", int'(cap[2]), 16'h0001);
    check_output("line0_px3", int'(cap[3]), 16'h0001);
    check_output("line0_last", int'(cap[639]), 16'h013F);
    check_output("line1_px0", int'(cap[640]), 16'h0000);
    check_output("line1_px3", int'(cap[643]), 16'h0001);
    check_output("line2_px0", int'(cap[1280]), 16'h0140);
    check_output("line2_px2", int'(cap[1282]), 16'h0141);
    check_output("line7_px0", int'(cap[4480]), 16'h03C0);
    check_output("line6_last", int'(cap[4479]), 16'h04FF);
    check_output("line7_last", int'(cap[5119]), 16'h04FF);

    wait_cyc(2 * F + 500);
    colour_mode = 1;
    push_frame();
    wait_cyc(2 * F + 1000);
    enable = 1'b1;
    wait_cyc(3 * F + 1);
    check_output("frame2_blank_de_count", de_seen - snap, 0);

    wait_cyc(3 * F + 100);
    check_output("f81f_red", int'(cap[0][15:11]), 31);
    check_output("f81f_green", int'(cap[0][10:5]), 0);
    check_output("f81f_blue", int'(cap[0][4:0]), 31);
    check_output("07e0_red", int'(cap[2][15:11]), 0);
    check_output("07e0_green", int'(cap[2][10:5]), 63);
    check_output("07e0_blue", int'(cap[2][4:0]), 0);
    check_output("frame3_resume_px4", int'(cap[4]), 2);

    wait_cyc(3 * F + 800 + 705);
    check_output("pre_reset_hsync_low", int'(hsync), 0);
    check_output("pre_reset_address_held", int'(vram_address), 319);
    #1 rst_n = 1'b0;
    #1;
    check_output("async_reset_hsync", int'(hsync), 1);
    check_output("async_reset_vsync", int'(vsync), 1);
    check_output("async_reset_de", int'(de), 0);
    check_output("async_reset_address", int'(vram_address), 0);
    check_output("async_reset_rgb", int'({red, green, blue}), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    snap = de_seen;
    wait_cyc(3);
    check_output("frame_start_after_reset", int'(frame_start), 1);
    wait_cyc(F + 1);
    check_output("post_reset_frame_blank", de_seen - snap, 0);
  endtask

  initial begin
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side consumer of the 320x240x16 dual-port VRAM. Generates 640x480@60 VGA timing from one pixel clock, addresses VRAM read port B with 2x horizontal and vertical pixel replication, and emits RGB565 pixels split into 5/6/5 channels. Every output is aligned to the VRAM's one-cycle registered read latency.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- FB_WIDTH / FB_HEIGHT, 320 / 240, framebuffer dimensions (H_ACTIVE = 2*FB_WIDTH, V_ACTIVE = 2*FB_HEIGHT)
- i_clk  in  1  pixel clock, 25.175 MHz nominal
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  scanout enable, sampled only at frame start
- o_vram_address  out  17  VRAM port B address; the port B write enable is tied 0 at top level
- i_vram_rd_data  in  16  VRAM port B read data, RGB565, valid one clock after the address
- o_hsync  out  1  active-low horizontal sync
- o_vsync  out  1  active-low vertical sync
- o_de  out  1  data enable, high during visible pixels of an enabled frame
- o_red  out  5  red, i_vram_rd_data[15:11]
- o_green  out  6  green, [10:5]
- o_blue  out  5  blue, [4:0]
- o_frame_start  out  1  one-clock pulse aligned with the first pixel slot of each frame

## Operation
- Counters: h_cnt 0..799 and v_cnt 0..524. h_cnt wraps 799->0 and increments v_cnt. v_cnt wraps 524->0.
- Active region: h_cnt < 640 and v_cnt < 480. Hsync is low for h_cnt in [656, 751]. Vsync is low for v_cnt in [490, 491].
- Address: line_base + (h_cnt >> 1). line_base is 0 at v_cnt = 0. At h_cnt = 799 of an odd active line (v_cnt odd, < 480), line_base increases by 320. line_base returns to 0 at frame wrap. Addressing uses no multiplier.
- Outside the active region, the address holds the last active value. Last address of a frame is 76799.
- frame_en register: loaded from i_enable when h_cnt = 799 and v_cnt = 524. Reset value is 0. When frame_en = 0, o_de = 0 and RGB = 0 for the whole frame. Syncs run regardless of frame_en.
- RGB outputs are 0 whenever the aligned de is 0.

## Timing
- Pipeline:
  - Stage 0: counters.
  - Stage 1: o_vram_address registered.
  - Stage 2: VRAM data returns.
  - Stage 3: RGB registered.
- hsync, vsync, de and frame_start are computed at stage 0 and delayed through 3 registers. Every output reflects counter state from 3 clocks earlier.
- First visible pixel (address 0) appears on o_red/green/blue 3 clocks after h_cnt = v_cnt = 0, together with o_de rising and o_frame_start.
- Each framebuffer pixel is presented for 2 consecutive clocks. Each framebuffer line is presented on 2 consecutive output lines.
- Reset values (asynchronous):
  - Counters, line_base and o_vram_address: 0.
  - o_hsync, o_vsync: 1.
  - o_de, o_frame_start, RGB: 0.
  - Delay-line registers: the inactive values above.
- Reset mid-frame: immediate return to those values. After release, the first clock is h_cnt = v_cnt = 0 and frame_en = 0, so the first frame after reset is always blank.
- Enable toggled mid-frame: no effect until the next frame boundary.

## Structure
- Package vga_pkg:
  - Default timing localparams (640x480@60 values).
  - FB dimension constants.
  - ADDR_W = 17.
  - Function rgb565_split returning the 5/6/5 fields.
- Sub-module vga_timing: h/v counters, sync generation, active flag, frame-boundary strobe.
- vga_scanout instantiates vga_timing and owns address generation, frame_en and the 3-stage alignment pipeline.

## Test plan
- Reset: assert i_rst_n = 0 mid-line -> o_hsync = o_vsync = 1, o_de = 0, o_vram_address = 0, RGB = 0 within the same clock (asynchronous). After release, frame 0 shows o_de = 0 throughout.
- Sync geometry: run 2 frames with a behavioural VRAM model (1-clock latency) -> hsync low for exactly 96 clocks per 800; vsync low for exactly 2 lines (1600 clocks) per 525 lines; 420000 clocks per frame.
- Replication: VRAM content = address value -> on line 0, outputs for pixels 0,1 = 0x0000 and 2,3 = 0x0001; output lines 0 and 1 identical; output line 2 starts with 320 (0x0140).
- Wrap: final visible pixel of an enabled frame = 76799 (0x12BFF), shown twice on lines 478 and 479. The next frame's first pixel is 0, with o_frame_start high on that clock.
- Colour split: VRAM word 0xF81F at address 0 -> o_red = 31, o_green = 0, o_blue = 31; word 0x07E0 -> o_green = 63, red = blue = 0.
- Enable: drop i_enable at line 100 of an enabled frame -> the frame completes normally; the next frame has o_de = 0 and RGB = 0 with syncs unchanged. Raise it again -> the following frame resumes at address 0.
